// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, even parity check,
// and a single-entry output register with valid/ready handshake and sticky overrun.
module uart_rx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx,
    input  logic         rx_ready,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic         rx_parity_err,
    output logic         rx_frame_err,
    output logic         rx_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(N + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_reg;
    logic          rx_meta_reg;
    logic          rx_s;
    logic [CW-1:0] cnt_reg;
    logic [BW-1:0] bit_reg;
    logic [N-1:0]  shift_reg;
    logic          parity_err_reg;
    logic          tick_half;
    logic          tick_full;

    assign tick_half = (cnt_reg == HALF_LAST);
    assign tick_full = (cnt_reg == FULL_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rx_meta_reg    <= 1'b1;
            rx_s           <= 1'b1;
            cnt_reg        <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            parity_err_reg <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rx_parity_err  <= 1'b0;
            rx_frame_err   <= 1'b0;
            rx_overrun     <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_s        <= rx_meta_reg;

            // A reload in STOP below overrides this drop, keeping rx_valid high.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (tick_half) begin
                        cnt_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DATA: begin
                    if (tick_full) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s, shift_reg[N-1:1]};
                        bit_reg   <= bit_reg + BW'(1);
                        if (bit_reg == LAST_BIT) begin
                            state_reg <= PARITY;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                PARITY: begin
                    if (tick_full) begin
                        cnt_reg        <= '0;
                        parity_err_reg <= (^shift_reg) ^ rx_s;
                        state_reg      <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                STOP: begin
                    if (tick_full) begin
                        cnt_reg <= '0;
                        if (!rx_valid || rx_ready) begin
                            rx_data       <= shift_reg;
                            rx_parity_err <= parity_err_reg;
                            rx_frame_err  <= !rx_s;
                            rx_valid      <= 1'b1;
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                        state_reg <= rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames, checked by a queue-based
// scoreboard that a free-running monitor drains on every accepted word.
module tb_uart_rx;

    localparam int N   = 8;
    localparam int CPB = 16;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         rx       = 1'b1;
    logic         rx_ready = 1'b0;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         rx_parity_err;
    logic         rx_frame_err;
    logic         rx_overrun;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          fall_cyc    = 0;
    int          rise_cyc    = -1000;
    int          low_run     = 0;
    logic        prev_valid  = 1'b0;
    logic        ready_cmd   = 1'b0;
    bit          rand_ready  = 1'b0;
    logic [31:0] exp_q[$];

    uart_rx #(.N(N), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected word: {frame_err, parity_err, data}; parity is even over data plus parity bit.
    function automatic logic [31:0] expect_word(input logic [7:0] d, input logic par, input logic stop);
        logic perr;
        perr = ((($countones(d) + int'(par)) % 2) != 0);
        return {21'b0, ~stop, perr, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit expect_it);
        if (expect_it) exp_q.push_back(expect_word(d, par, stop));
        fall_cyc = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < N; i++) hold(d[i], CPB);
        hold(par, CPB);
        hold(stop, CPB);
    endtask

    // Consumer: either follows ready_cmd or toggles randomly, never low more than 6 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) begin
                rx_ready = (low_run >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                low_run  = rx_ready ? 0 : low_run + 1;
            end else begin
                rx_ready = ready_cmd;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rx_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = rx_valid;
            if (rst_n && rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %h, expected no word", rx_data);
                end else begin
                    check("rx_word", {21'b0, rx_frame_err, rx_parity_err, rx_data}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         lat;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {rx_overrun, rx_frame_err, rx_parity_err, rx_valid, rx_data}, 32'h0);
        rst_n     = 1'b1;
        ready_cmd = 1'b1;
        hold(1'b1, 10);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        hold(1'b1, CPB);
        lat = rise_cyc - fall_cyc;
        vectors++;
        if (lat < 169 || lat > 171) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, expected 169..171", lat);
        end

        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        hold(1'b1, CPB);

        // Stop bit low, then the line stays low: one word only, flagged as framing error.
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        hold(1'b0, 40);
        check("low_line_no_valid", rx_valid, 1'b0);
        check("frame_err_held", rx_frame_err, 1'b1);
        hold(1'b1, 20);

        hold(1'b0, 4);
        hold(1'b1, 30);
        check("false_start_no_valid", rx_valid, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        hold(1'b1, CPB);
        check("after_glitch_data", rx_data, 32'h81);

        ready_cmd = 1'b0;
        hold(1'b1, 4);
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        hold(1'b1, CPB);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        hold(1'b1, CPB);
        check("ovr_data", rx_data, 32'h11);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_flag", rx_overrun, 1'b1);
        ready_cmd = 1'b1;
        hold(1'b1, 4);
        check("ovr_valid_cleared", rx_valid, 1'b0);
        check("ovr_sticky", rx_overrun, 1'b1);

        // Reset pulse in the middle of the data bits of 0x55; the line then idles.
        d = 8'h55;
        hold(1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(d[i], CPB);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx    = 1'b1;
        check("mid_reset_outputs", {rx_overrun, rx_frame_err, rx_parity_err, rx_valid, rx_data}, 32'h0);
        hold(1'b1, CPB * 12);
        check("mid_reset_no_valid", rx_valid, 1'b0);
        send_frame(8'h66, 1'b0, 1'b1, 1'b1);
        hold(1'b1, CPB);
        check("after_reset_data", rx_data, 32'h66);

        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            d    = 8'($urandom);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, par, stop, 1'b1);
            hold(1'b1, $urandom_range(2, 20));
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        hold(1'b1, CPB * 2);

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'h0);
        check("no_overrun_random", rx_overrun, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: N, 8, data bits per frame.
REQ-002 Parameter: CLKS_PER_BIT, 16, clk cycles per bit period; even, >= 4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 rx  input  1  asynchronous serial line; idle high.
REQ-006 rx_ready  input  1  consumer accepts held word when high while rx_valid high.
REQ-007 rx_data  output  N  last received data word, LSB = first data bit on line.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-009 rx_parity_err  output  1  parity mismatch on the word in rx_data.
REQ-010 rx_frame_err  output  1  stop bit sampled low on the word in rx_data.
REQ-011 rx_overrun  output  1  sticky; a frame completed while rx_valid was high and unconsumed.

Function
REQ-012 Frame format SHALL be: 1 start (0), N data LSB first, 1 even-parity bit, 1 stop (1).
REQ-013 rx SHALL pass through a 2-flop synchronizer (reset value 1); all logic SHALL use the synchronized value rx_s.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 IDLE: on rx_s == 0, go to START and clear the bit-period counter.
REQ-016 START: after CLKS_PER_BIT/2 cycles, sample rx_s; 1 -> false start, back to IDLE, no output change; 0 -> DATA, counter cleared.
REQ-017 DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit), shift into a shift register; after the N-th sample go to PARITY.
REQ-018 PARITY: sample one bit after CLKS_PER_BIT cycles; error = XOR(data bits, parity bit) != 0.
REQ-019 STOP: sample after CLKS_PER_BIT cycles; in that same cycle update the output register (REQ-020), then go to IDLE if rx_s == 1, else WAIT_HIGH.
REQ-020 Output register update at stop sample: if rx_valid == 0 or rx_ready == 1 that cycle, load rx_data, rx_parity_err, rx_frame_err and set rx_valid = 1; otherwise keep the old word and flags, drop the new frame, and set rx_overrun = 1.
REQ-021 WAIT_HIGH: stay until rx_s == 1, then go to IDLE; a line held low SHALL NOT start a new frame.
REQ-022 Handshake: rx_valid falls the cycle after rx_valid && rx_ready, unless REQ-020 reloads in that same cycle, in which case rx_valid stays 1.
REQ-023 rx_data and the error flags SHALL stay stable while rx_valid == 1 and no transfer occurs.
REQ-024 rx_overrun SHALL clear only on reset.
REQ-025 Latency: rx_valid rises the cycle after the stop sample, which is 2 + CLKS_PER_BIT/2 + (N+2)*CLKS_PER_BIT cycles after the falling edge of rx, within +/-1 cycle.
REQ-026 rx_ready while rx_valid == 0 SHALL have no effect.

Reset
REQ-027 With rst_n low at a clock edge: FSM -> IDLE, counters and shift register -> 0, synchronizer -> 1, rx_data -> 0, rx_valid/rx_parity_err/rx_frame_err/rx_overrun -> 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no rx_valid for it; reception resumes from the next start bit after rst_n goes high.

Verification (N=8, CLKS_PER_BIT=16)
REQ-029 Frame 0xA5, parity 0, stop 1, rx_ready held 1 -> rx_data=0xA5, rx_valid high 1 cycle, all error flags 0.
REQ-030 Frame 0x3C, parity 1 -> rx_data=0x3C, rx_parity_err=1, rx_frame_err=0.
REQ-031 Frame 0x00, parity 0, stop 0, line then held low 40 cycles -> rx_frame_err=1; no second rx_valid until rx is high and a new start bit arrives.
REQ-032 rx low pulse of 4 cycles -> no rx_valid; next valid frame 0x81 received correctly.
REQ-033 rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11, rx_valid=1, rx_overrun=1; assert rx_ready -> rx_valid falls, rx_overrun stays 1.
REQ-034 rst_n low for 1 cycle mid-DATA of frame 0x55 -> no rx_valid, all outputs 0; following frame 0x66 -> rx_data=0x66.
